// File: rtl/led_pkg.sv
// Shared encodings, seeds and defaults for the LED pattern generator.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_ROT    = 2'b00,
        MODE_BOUNCE = 2'b01,
        MODE_COUNT  = 2'b10,
        MODE_BLINK  = 2'b11
    } led_mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } led_dir_e;

    localparam logic [15:0] SEED_ROT    = 16'h0001;
    localparam logic [15:0] SEED_BOUNCE = 16'h0001;
    localparam logic [15:0] SEED_COUNT  = 16'h0000;
    localparam logic [15:0] SEED_BLINK  = 16'h00FF;

    localparam int unsigned LED_DIV_W_DEFAULT    = 24;
    localparam logic [23:0] LED_BASE_DIV_DEFAULT = 24'd12_500_000;

    // Observable pattern-engine state, exported for checkers and debug.
    typedef struct packed {
        led_mode_e   mode;
        led_dir_e    dir;
        logic [15:0] led;
    } led_dbg_t;

    function automatic logic [15:0] mode_seed(input led_mode_e m);
        logic [15:0] seed;
        case (m)
            MODE_ROT:    seed = SEED_ROT;
            MODE_BOUNCE: seed = SEED_BOUNCE;
            MODE_COUNT:  seed = SEED_COUNT;
            MODE_BLINK:  seed = SEED_BLINK;
            default:     seed = SEED_ROT;
        endcase
        return seed;
    endfunction

endpackage

// File: rtl/led_pattern_gen_if.sv
// Control/status bundle of the LED pattern generator; the master drives controls,
// the slave (the generator) returns the pattern. dim_duty exists only with LED_PWM_DIM_EN.
interface led_pattern_gen_if;

    // No handshake: load is a one-cycle strobe sampled on every rising edge,
    // the other controls are levels, and led_word/step_tick are always valid.
    logic [1:0]  mode;
    logic [2:0]  speed;
    logic        pause;
    logic        load;
    logic [15:0] load_value;
    logic [15:0] led_word;
    logic        step_tick;
`ifdef LED_PWM_DIM_EN
    logic [3:0]  dim_duty;

    modport master (
        output mode, speed, pause, load, load_value, dim_duty,
        input  led_word, step_tick
    );

    modport slave (
        input  mode, speed, pause, load, load_value, dim_duty,
        output led_word, step_tick
    );
`else
    modport master (
        output mode, speed, pause, load, load_value,
        input  led_word, step_tick
    );

    modport slave (
        input  mode, speed, pause, load, load_value,
        output led_word, step_tick
    );
`endif

endinterface

// File: rtl/led_prescaler.sv
// Programmable step-rate divider: tick once every max(BASE_DIV >> speed, 1) unpaused cycles.
module led_prescaler
    import led_pkg::*;
#(
    parameter int unsigned      DIV_W    = LED_DIV_W_DEFAULT,
    parameter logic [DIV_W-1:0] BASE_DIV = DIV_W'(LED_BASE_DIV_DEFAULT)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] speed_i,
    input  logic       pause_i,
    input  logic       clear_i,
    output logic       tick_o
);

    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;
    logic [DIV_W-1:0] period;
    logic [DIV_W-1:0] last_cnt;
    logic             wrap;

    // A zero period (large shift) is treated as one cycle per step.
    always_comb begin
        period   = BASE_DIV >> speed_i;
        last_cnt = (period == '0) ? '0 : period - DIV_W'(1);
    end

    // >= rather than == so that a speed increase past the current count
    // wraps on the very next cycle instead of running around the counter.
    assign wrap   = (div_cnt_q >= last_cnt);
    assign tick_o = !pause_i && wrap;

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (clear_i) begin
            div_cnt_d = '0;
        end else if (!pause_i) begin
            div_cnt_d = wrap ? '0 : div_cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// 16-bit LED pattern source (rotate, bounce, count, blink) with load and pause.
// Optional LED_PWM_DIM_EN adds a 4-bit PWM dimmer driven by dim_duty.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int unsigned      DIV_W    = LED_DIV_W_DEFAULT,
    parameter logic [DIV_W-1:0] BASE_DIV = DIV_W'(LED_BASE_DIV_DEFAULT)
) (
    input  logic               clk,
    input  logic               rst_n,
    led_pattern_gen_if.slave   bus,
    output led_dbg_t           dbg_o
);

    led_mode_e   mode_q;
    led_dir_e    dir_q;
    logic [15:0] led_q;
    logic        step_tick_q;

    led_mode_e   mode_in;
    logic        mode_chg;
    logic        clear;
    logic        tick;
    logic [15:0] step_led_d;
    led_dir_e    step_dir_d;

    assign mode_in  = led_mode_e'(bus.mode);
    assign mode_chg = (mode_in != mode_q);
    assign clear    = bus.load || mode_chg;

    led_prescaler #(
        .DIV_W    (DIV_W),
        .BASE_DIV (BASE_DIV)
    ) u_prescaler (
        .clk     (clk),
        .rst_n   (rst_n),
        .speed_i (bus.speed),
        .pause_i (bus.pause),
        .clear_i (clear),
        .tick_o  (tick)
    );

    // Next pattern for one step of the current mode.
    always_comb begin
        step_led_d = led_q;
        step_dir_d = dir_q;
        case (mode_q)
            MODE_ROT: begin
                step_led_d = {led_q[14:0], led_q[15]};
            end
            MODE_BOUNCE: begin
                // Reverse and step inward in the same cycle, so an edge bit
                // is shown once and never falls off.
                if (dir_q == DIR_LEFT) begin
                    if (led_q[15]) begin
                        step_dir_d = DIR_RIGHT;
                        step_led_d = led_q >> 1;
                    end else begin
                        step_led_d = led_q << 1;
                    end
                end else begin
                    if (led_q[0]) begin
                        step_dir_d = DIR_LEFT;
                        step_led_d = led_q << 1;
                    end else begin
                        step_led_d = led_q >> 1;
                    end
                end
            end
            MODE_COUNT: begin
                step_led_d = led_q + 16'd1;
            end
            MODE_BLINK: begin
                step_led_d = ~led_q;
            end
            default: begin
                step_led_d = led_q;
            end
        endcase
    end

    // Pattern engine: load beats mode change beats pause/tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= MODE_ROT;
            dir_q       <= DIR_LEFT;
            led_q       <= SEED_ROT;
            step_tick_q <= 1'b0;
        end else begin
            step_tick_q <= 1'b0;
            if (bus.load) begin
                led_q <= bus.load_value;
            end else if (mode_chg) begin
                mode_q <= mode_in;
                dir_q  <= DIR_LEFT;
                led_q  <= mode_seed(mode_in);
            end else if (tick) begin
                led_q       <= step_led_d;
                dir_q       <= step_dir_d;
                step_tick_q <= 1'b1;
            end
        end
    end

`ifdef LED_PWM_DIM_EN
    logic [3:0] pwm_cnt_q;
    logic       pwm_on_q;

    // The duty compare is registered so dim_duty never reaches led_word combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q <= 4'd0;
            pwm_on_q  <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 4'd1;
            pwm_on_q  <= (pwm_cnt_q < bus.dim_duty);
        end
    end

    assign bus.led_word = led_q & {16{pwm_on_q}};
`else
    assign bus.led_word = led_q;
`endif

    assign bus.step_tick = step_tick_q;

    assign dbg_o.mode = mode_q;
    assign dbg_o.dir  = dir_q;
    assign dbg_o.led  = led_q;

endmodule
